game_ctrl_param: RTL and testbench

- Parametrised move controller for the Connect-4 game. It generalises the fixed 7x6, two-player controller to any board size and any player count.
- Takes a one-hot column selection with a `go` strobe and validates the move.
- Finds the lowest free row in the chosen column and issues one write transaction to the board-RAM drawer, handshaked by `draw_done`.
- Rotates the current player, tracks per-column fill, rejects illegal moves and detects a full board (drawn game).

---
 rtl/game_pkg.sv | 30 +++
 rtl/onehot_to_index.sv | 22 ++
 rtl/game_ctrl_param.sv | 120 ++++++++++++
 tb/tb_game_ctrl_param.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the parametrised Connect-4 move controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_DRAW    = 3'd2,
    ST_NEXT    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  localparam int EMPTY_CODE = 0;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2w(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Player codes run 1..players and wrap back to 1.
  function automatic int next_player(input int p, input int players);
    return (p >= players) ? 1 : p + 1;
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Combinational one-hot decoder: index of the lowest set bit plus an exactly-one flag.
module onehot_to_index
  import game_pkg::*;
#(
  parameter int N = 7,
  localparam int IW = clog2w(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] index,
  output logic          exactly_one
);

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) index = IW'(i);
    end
  end

  assign exactly_one = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/game_ctrl_param.sv
// Connect-4 move controller for any board size and player count: validates a
// column press, issues one drawer write, rotates players and detects a full board.
module game_ctrl_param
  import game_pkg::*;
#(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int PLAYERS = 2,
  localparam int CW = clog2w(COLS),
  localparam int RW = clog2w(ROWS),
  localparam int PW = clog2w(PLAYERS + 1),
  localparam int MW = clog2w(ROWS * COLS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] column_in,
  input  logic            go,
  input  logic            new_game,
  input  logic            draw_done,
  output logic            wr_valid,
  output logic [CW-1:0]   wr_col,
  output logic [RW-1:0]   wr_row,
  output logic [PW-1:0]   wr_player,
  output logic [PW-1:0]   player_out,
  output logic [COLS-1:0] col_full,
  output logic            reject,
  output logic            game_over,
  output logic [MW-1:0]   move_count,
  output state_t          state_dbg
);

  localparam int HW = RW + 1;

  state_t          state_q, state_d;
  logic [COLS-1:0] col_q;
  logic [HW-1:0]   height_q [COLS];
  logic [CW-1:0]   sel_idx;
  logic            sel_one;
  logic            legal;
  logic            clear;
  logic            board_full_next;

  onehot_to_index #(.N(COLS)) u_sel (
    .vec         (col_q),
    .index       (sel_idx),
    .exactly_one (sel_one)
  );

  assign legal           = sel_one && (height_q[sel_idx] < HW'(ROWS));
  assign board_full_next = (move_count + MW'(1)) == MW'(ROWS * COLS);

  // new_game is not honoured while a drawer write is in flight (DRAW/NEXT).
  assign clear = new_game && (state_q == ST_IDLE || state_q == ST_CHECK ||
                              state_q == ST_RELEASE || state_q == ST_OVER);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (clear) state_d = ST_RELEASE;
                  else if (go) state_d = ST_CHECK;
      ST_CHECK:   if (clear) state_d = ST_RELEASE;
                  else if (legal) state_d = ST_DRAW;
                  else state_d = ST_RELEASE;
      ST_DRAW:    if (draw_done) state_d = ST_NEXT;
      ST_NEXT:    state_d = board_full_next ? ST_OVER : ST_RELEASE;
      ST_RELEASE: if (clear) state_d = ST_RELEASE;
                  else if (!go) state_d = ST_IDLE;
      ST_OVER:    if (clear) state_d = ST_RELEASE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Drawer handshake: wr_valid is held with stable wr_* until draw_done is
  // seen high on a clock edge; that edge completes the write and drops wr_valid.
  always_comb begin
    wr_valid  = (state_q == ST_DRAW);
    reject    = (state_q == ST_CHECK) && !legal && !new_game;
    game_over = (state_q == ST_OVER);
    state_dbg = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col_q      <= '0;
      wr_col     <= '0;
      wr_row     <= '0;
      wr_player  <= PW'(EMPTY_CODE);
      player_out <= PW'(1);
      move_count <= '0;
      col_full   <= '0;
      for (int i = 0; i < COLS; i++) height_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) col_q <= column_in;
        end
        ST_CHECK: begin
          if (legal) begin
            wr_col    <= sel_idx;
            wr_row    <= RW'(height_q[sel_idx]);
            wr_player <= player_out;
          end
        end
        ST_NEXT: begin
          height_q[wr_col] <= height_q[wr_col] + HW'(1);
          col_full[wr_col] <= (height_q[wr_col] + HW'(1)) == HW'(ROWS);
          move_count       <= move_count + MW'(1);
          player_out       <= PW'(next_player(int'(player_out), PLAYERS));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl_param.sv
// Bench for game_ctrl_param: directed table, hand-written corner sequences and
// random moves against a board model, on a default and a 2x2/3-player instance.
module tb_game_ctrl_param;
  import game_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance: 7 cols, 6 rows, 2 players
  logic       a_reset, a_go, a_new_game, a_draw_done;
  logic [6:0] a_column_in;
  logic       a_wr_valid, a_reject, a_game_over;
  logic [2:0] a_wr_col, a_wr_row;
  logic [1:0] a_wr_player, a_player_out;
  logic [6:0] a_col_full;
  logic [5:0] a_move_count;
  state_t     a_state;

  game_ctrl_param u_a (
    .clk(clk), .reset(a_reset), .column_in(a_column_in), .go(a_go),
    .new_game(a_new_game), .draw_done(a_draw_done), .wr_valid(a_wr_valid),
    .wr_col(a_wr_col), .wr_row(a_wr_row), .wr_player(a_wr_player),
    .player_out(a_player_out), .col_full(a_col_full), .reject(a_reject),
    .game_over(a_game_over), .move_count(a_move_count), .state_dbg(a_state)
  );

  // Small instance: 2 cols, 2 rows, 3 players
  logic       b_reset, b_go, b_new_game, b_draw_done;
  logic [1:0] b_column_in;
  logic       b_wr_valid, b_reject, b_game_over;
  logic [0:0] b_wr_col, b_wr_row;
  logic [1:0] b_wr_player, b_player_out;
  logic [1:0] b_col_full;
  logic [2:0] b_move_count;
  state_t     b_state;

  game_ctrl_param #(.COLS(2), .ROWS(2), .PLAYERS(3)) u_b (
    .clk(clk), .reset(b_reset), .column_in(b_column_in), .go(b_go),
    .new_game(b_new_game), .draw_done(b_draw_done), .wr_valid(b_wr_valid),
    .wr_col(b_wr_col), .wr_row(b_wr_row), .wr_player(b_wr_player),
    .player_out(b_player_out), .col_full(b_col_full), .reject(b_reject),
    .game_over(b_game_over), .move_count(b_move_count), .state_dbg(b_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Board model for the default instance
  int m_h[7];
  int m_count;
  int m_player;
  bit m_over;

  function automatic void m_reset();
    foreach (m_h[i]) m_h[i] = 0;
    m_count  = 0;
    m_player = 1;
    m_over   = 0;
  endfunction

  function automatic logic [6:0] m_full();
    logic [6:0] f;
    foreach (m_h[i]) f[i] = (m_h[i] == 6);
    return f;
  endfunction

  function automatic void m_predict(input logic [6:0] cv, output bit ign, output bit rej,
                                    output int col, output int row, output int pl);
    ign = m_over; rej = 0; col = 0; row = 0; pl = m_player;
    if (!ign) begin
      if ($countones(cv) != 1) rej = 1;
      else begin
        for (int i = 0; i < 7; i++) if (cv[i]) col = i;
        if (m_h[col] >= 6) rej = 1;
        else row = m_h[col];
      end
    end
  endfunction

  task automatic a_play(input logic [6:0] cv, input bit ign, input bit rej, input int col,
                        input int row, input int pl, input int delay, input bit keep_go);
    @(negedge clk);
    a_column_in = cv;
    a_go = 1'b1;
    @(negedge clk);
    check("reject", a_reject, (rej && !ign) ? 1 : 0);
    @(negedge clk);
    check("reject_pulse", a_reject, 0);
    if (ign || rej) begin
      check("no_write", a_wr_valid, 0);
      check("count_hold", a_move_count, m_count);
      check("player_hold", a_player_out, m_player);
      check("game_over_hold", a_game_over, m_over);
    end else begin
      check("wr_valid", a_wr_valid, 1);
      check("wr_col", a_wr_col, col);
      check("wr_row", a_wr_row, row);
      check("wr_player", a_wr_player, pl);
      repeat (delay) begin
        @(negedge clk);
        check("wr_valid_hold", a_wr_valid, 1);
        check("wr_col_hold", a_wr_col, col);
      end
      a_draw_done = 1'b1;
      @(negedge clk);
      a_draw_done = 1'b0;
      check("wr_valid_drop", a_wr_valid, 0);
      m_h[col]++;
      m_count++;
      m_player = (m_player % 2) + 1;
      m_over = (m_count == 42);
      @(negedge clk);
      check("player_out", a_player_out, m_player);
      check("move_count", a_move_count, m_count);
      check("col_full", a_col_full, m_full());
      check("game_over", a_game_over, m_over);
    end
    if (!keep_go) a_go = 1'b0;
    @(negedge clk);
  endtask

  task automatic a_newgame();
    @(negedge clk);
    a_go = 1'b0;
    a_new_game = 1'b1;
    @(negedge clk);
    a_new_game = 1'b0;
    check("ng_count", a_move_count, 0);
    check("ng_player", a_player_out, 1);
    check("ng_col_full", a_col_full, 0);
    check("ng_game_over", a_game_over, 0);
    m_reset();
    @(negedge clk);
  endtask

  task automatic b_move(input logic [1:0] cv, input int col, input int row, input int pl);
    @(negedge clk);
    b_column_in = cv;
    b_go = 1'b1;
    @(negedge clk);
    check("b_reject", b_reject, 0);
    @(negedge clk);
    check("b_wr_valid", b_wr_valid, 1);
    check("b_wr_col", b_wr_col, col);
    check("b_wr_row", b_wr_row, row);
    check("b_wr_player", b_wr_player, pl);
    b_draw_done = 1'b1;
    @(negedge clk);
    b_draw_done = 1'b0;
    @(negedge clk);
    b_go = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [6:0] cv;
    bit         rej;
    int         col;
    int         row;
    int         pl;
  } vec_t;

  vec_t a_vec[11];
  vec_t b_vec[4];

  initial begin
    bit ign, rej;
    int col, row, pl, c0;
    logic [6:0] cv;

    a_vec[0]  = '{7'b0000100, 0, 2, 0, 1};
    a_vec[1]  = '{7'b0000100, 0, 2, 1, 2};
    a_vec[2]  = '{7'b0000100, 0, 2, 2, 1};
    a_vec[3]  = '{7'b0000100, 0, 2, 3, 2};
    a_vec[4]  = '{7'b0000100, 0, 2, 4, 1};
    a_vec[5]  = '{7'b0000100, 0, 2, 5, 2};
    a_vec[6]  = '{7'b0000100, 1, 0, 0, 1};
    a_vec[7]  = '{7'b0000000, 1, 0, 0, 1};
    a_vec[8]  = '{7'b0011000, 1, 0, 0, 1};
    a_vec[9]  = '{7'b0000001, 0, 0, 0, 1};
    a_vec[10] = '{7'b1000000, 0, 6, 0, 2};
    b_vec[0] = '{7'b0000001, 0, 0, 0, 1};
    b_vec[1] = '{7'b0000010, 0, 1, 0, 2};
    b_vec[2] = '{7'b0000001, 0, 0, 1, 3};
    b_vec[3] = '{7'b0000010, 0, 1, 1, 1};

    a_reset = 1'b1; a_go = 1'b0; a_new_game = 1'b0; a_draw_done = 1'b0; a_column_in = '0;
    b_reset = 1'b1; b_go = 1'b0; b_new_game = 1'b0; b_draw_done = 1'b0; b_column_in = '0;
    m_reset();
    repeat (3) @(negedge clk);
    a_reset = 1'b0;
    b_reset = 1'b0;
    check("rst_wr_valid", a_wr_valid, 0);
    check("rst_wr_col", a_wr_col, 0);
    check("rst_wr_row", a_wr_row, 0);
    check("rst_wr_player", a_wr_player, 0);
    check("rst_player", a_player_out, 1);
    check("rst_col_full", a_col_full, 0);
    check("rst_reject", a_reject, 0);
    check("rst_game_over", a_game_over, 0);
    check("rst_count", a_move_count, 0);

    // Directed table: fill column 2, overflow, malformed selections
    for (int i = 0; i < 11; i++)
      a_play(a_vec[i].cv, 0, a_vec[i].rej, a_vec[i].col, a_vec[i].row, a_vec[i].pl, i % 3, 0);

    // Held go: exactly one write until go drops
    m_predict(7'b0000010, ign, rej, col, row, pl);
    a_play(7'b0000010, ign, rej, col, row, pl, 1, 1);
    repeat (4) begin
      @(negedge clk);
      check("held_no_write", a_wr_valid, 0);
      check("held_count", a_move_count, m_count);
    end
    a_go = 1'b0;
    @(negedge clk);
    m_predict(7'b0000010, ign, rej, col, row, pl);
    a_play(7'b0000010, ign, rej, col, row, pl, 0, 0);

    // draw_done outside DRAW does nothing
    a_draw_done = 1'b1;
    @(negedge clk);
    a_draw_done = 1'b0;
    check("stray_done_count", a_move_count, m_count);
    check("stray_done_valid", a_wr_valid, 0);
    @(negedge clk);

    // new_game during DRAW deferred until the write completes
    c0 = m_count;
    a_column_in = 7'b0100000;
    a_go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_new_game = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ng_draw_valid", a_wr_valid, 1);
    check("ng_draw_count", a_move_count, c0);
    a_draw_done = 1'b1;
    @(negedge clk);
    a_draw_done = 1'b0;
    check("ng_draw_drop", a_wr_valid, 0);
    @(negedge clk);
    check("ng_after_move", a_move_count, c0 + 1);
    @(negedge clk);
    check("ng_clear_count", a_move_count, 0);
    check("ng_clear_player", a_player_out, 1);
    check("ng_clear_full", a_col_full, 0);
    a_new_game = 1'b0;
    a_go = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);

    // reset during DRAW abandons the request
    m_predict(7'b0001000, ign, rej, col, row, pl);
    a_play(7'b0001000, ign, rej, col, row, pl, 0, 0);
    a_column_in = 7'b0000100;
    a_go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rd_valid", a_wr_valid, 1);
    a_reset = 1'b1;
    @(negedge clk);
    check("rd_wr_valid", a_wr_valid, 0);
    check("rd_wr_col", a_wr_col, 0);
    check("rd_wr_row", a_wr_row, 0);
    check("rd_wr_player", a_wr_player, 0);
    check("rd_player", a_player_out, 1);
    check("rd_count", a_move_count, 0);
    check("rd_col_full", a_col_full, 0);
    check("rd_game_over", a_game_over, 0);
    a_reset = 1'b0;
    a_go = 1'b0;
    m_reset();
    @(negedge clk);

    // Random moves against the model
    for (int it = 0; it < 110; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) cv = 7'(1 << $urandom_range(0, 6));
      else if (r == 7) cv = '0;
      else cv = 7'($urandom_range(0, 127));
      m_predict(cv, ign, rej, col, row, pl);
      a_play(cv, ign, rej, col, row, pl, $urandom_range(0, 3), 0);
      if (m_over && $urandom_range(0, 2) == 0) a_newgame();
    end
    a_newgame();

    // Small board: 3-player rotation, full board, go ignored, new_game
    for (int i = 0; i < 4; i++)
      b_move(b_vec[i].cv[1:0], b_vec[i].col, b_vec[i].row, b_vec[i].pl);
    check("b_game_over", b_game_over, 1);
    check("b_col_full", b_col_full, 2'b11);
    check("b_count", b_move_count, 4);
    check("b_player_wrap", b_player_out, 2);
    b_column_in = 2'b01;
    b_go = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("b_over_no_write", b_wr_valid, 0);
      check("b_over_no_reject", b_reject, 0);
      check("b_over_hold", b_game_over, 1);
    end
    b_go = 1'b0;
    b_new_game = 1'b1;
    @(negedge clk);
    b_new_game = 1'b0;
    check("b_ng_full", b_col_full, 0);
    check("b_ng_count", b_move_count, 0);
    check("b_ng_player", b_player_out, 1);
    check("b_ng_over", b_game_over, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
